rf_access_sequencer: RTL and testbench
======================================

// Module: rf_access_sequencer
// PURPOSE
//  Initiator side of the 8x24 register-file port. Takes operand-fetch requests from the multicycle
//  control unit, drives read addresses, waits out the file's registered (1-clock) read, and returns
//  both operands through a valid/ready handshake. Also drives writeback and forwards same-edge or
//  later writes into in-flight and held operands.
// PARAMETERS
//  DATA_W    24  register/bus width
//  ADDR_W    3   register index width (2**ADDR_W registers)
//  ZERO_REG  1   1: register 0 reads as 0 and writes to it are dropped; 0: register 0 is ordinary
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous, active-low reset
//  op_valid    in   1       operand-fetch request
//  op_ready    out  1       request accepted when op_valid&op_ready at clk edge
//  op_rs       in   ADDR_W  source A index
//  op_rt       in   ADDR_W  source B index
//  opnd_valid  out  1       opnd_a/opnd_b valid
//  opnd_ready  in   1       consumer takes operands
//  opnd_a      out  DATA_W  operand A
//  opnd_b      out  DATA_W  operand B
//  wb_en       in   1       writeback this cycle (fire-and-forget, never stalled)
//  wb_reg      in   ADDR_W  writeback index
//  wb_data     in   DATA_W  writeback data
//  rf_ra       out  ADDR_W  to register file Ra (registered)
//  rf_rb       out  ADDR_W  to register file Rb (registered)
//  rf_rw       out  ADDR_W  to register file Rw = wb_reg (combinational)
//  rf_we       out  1       to enWrite = wb_en & !(ZERO_REG & wb_reg==0) (combinational)
//  rf_busw     out  DATA_W  to BusW = wb_data (combinational)
//  rf_busa     in   DATA_W  from BusA, valid one edge after rf_ra sampled
//  rf_busb     in   DATA_W  from BusB
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; op_ready=1; opnd_valid=0; opnd_a/b=0; rf_ra/rb=0; tags cleared.
//  FSM: IDLE -(accept)-> ISSUE -> CAPTURE -> HOLD -(opnd_ready)-> IDLE, or -> ISSUE if new op accepted.
//  op_ready = (state==IDLE) | (state==HOLD & opnd_ready). Accept latches op_rs/op_rt into rf_ra/rf_rb.
//  ISSUE: file samples rf_ra/rf_rb at end of cycle. CAPTURE: opnd_a/b <= rf_busa/rf_busb at end.
//  Latency: accept edge E0 -> opnd_valid=1 after E2. Back-to-back throughput 1 op per 3 clocks.
//  HOLD: opnd_valid=1, operands stable unless forwarded; release when opnd_ready=1.
//  Forwarding (per operand, independent; idx = latched rs/rt):
//   - write (rf_we=1) in ISSUE with wb_reg==idx: file returns old value; latch fwd tag+data, CAPTURE
//     loads wb_data instead of bus.
//   - write in CAPTURE with wb_reg==idx: CAPTURE loads wb_data (overrides bus and any ISSUE tag).
//   - write in HOLD with wb_reg==idx: held operand updated to wb_data, even on the release edge.
//   - rs==rt: both operands forward identically.
//  ZERO_REG=1: idx 0 yields 0 regardless of bus; wb_reg 0 forces rf_we=0 and never forwards.
//  Writes in IDLE go straight to the file; no state effect.
//  Reset mid-op: request and operands discarded; opnd_valid low until a new request completes.
// STRUCTURE
//  Package mips_rf_pkg: DATA_W, ADDR_W, ZERO_REG defaults; state enum {IDLE,ISSUE,CAPTURE,HOLD}.
//  Sub-module rf_opnd_fwd: one operand's index reg, fwd tag/data, capture/hold mux; instantiated for A and B.
//  Top level: FSM, handshakes, combinational write pass-through.
// TESTING
//  1 Preload r3=0x00ABCD, r5=0x123456 via wb; op rs=3 rt=5 -> opnd_valid 2 edges after accept,
//    a=0x00ABCD b=0x123456.
//  2 Op rs=2 with wb r2=0x0000FF in ISSUE -> opnd_a=0x0000FF; same write in CAPTURE -> 0x0000FF;
//    write r2=0x111111 in HOLD -> opnd_a becomes 0x111111.
//  3 ZERO_REG=1: wb r0=0xFFFFFF -> rf_we=0; op rs=0 rt=0 -> a=b=0x000000.
//  4 Hold opnd_ready=0 for 5 cycles -> opnd_valid stays 1, op_ready=0, values stable; then
//    opnd_ready=1 with op_valid=1 -> new op accepted same edge, next result after 2 more edges.
//  5 Assert rst_n=0 mid-CAPTURE -> opnd_valid/op_ready/rf_ra immediately 0/1/0; no stale result
//    after release.
//  6 rs==rt=4 with wb r4=0x00C0DE in ISSUE -> a=b=0x00C0DE.

Source files
------------

// File: rtl/rf_access_sequencer_pkg.sv
// Shared widths and FSM encoding for the register-file access sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mips_rf_pkg;

    localparam int RF_DATA_W   = 24;
    localparam int RF_ADDR_W   = 3;
    localparam bit RF_ZERO_REG = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/rf_access_sequencer_opnd_fwd.sv
// One operand lane: latched register index, same-edge write forwarding tag, and capture/hold register.
// Latency: operand loaded at the end of CAPTURE, two edges after the accept edge.
// Backpressure: none locally; the held value keeps tracking writes to its index until released.
module rf_opnd_fwd
    import mips_rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter bit ZERO_REG = RF_ZERO_REG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  state_t            state,
    input  logic              accept,
    input  logic [ADDR_W-1:0] new_idx,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rf_bus,
    output logic [ADDR_W-1:0] idx,
    output logic [DATA_W-1:0] opnd
);

    logic [ADDR_W-1:0] idx_q;
    logic              fwd_tag;
    logic [DATA_W-1:0] fwd_dat;
    logic [DATA_W-1:0] opnd_q;
    logic              wr_hit;
    logic              is_zero;

    // wr_en is already gated for register 0, so a zero index can never hit
    assign wr_hit  = wr_en && (wr_reg == idx_q);
    assign is_zero = ZERO_REG && (idx_q == '0);
    assign idx     = idx_q;
    assign opnd    = opnd_q;

    // Index latch, forwarding capture during ISSUE, operand load in CAPTURE and live update in HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            fwd_tag <= 1'b0;
            fwd_dat <= '0;
            opnd_q  <= '0;
        end else begin
            if (accept) begin
                idx_q   <= new_idx;
                fwd_tag <= 1'b0;
            end
            case (state)
                ISSUE: begin
                    // The file samples the old value on this edge; remember the new one
                    if (wr_hit) begin
                        fwd_tag <= 1'b1;
                        fwd_dat <= wr_data;
                    end
                end
                CAPTURE: begin
                    if (is_zero)
                        opnd_q <= '0;
                    else if (wr_hit)
                        opnd_q <= wr_data;
                    else if (fwd_tag)
                        opnd_q <= fwd_dat;
                    else
                        opnd_q <= rf_bus;
                end
                HOLD: begin
                    // Uses the old index even if a new request is accepted on this edge
                    if (wr_hit)
                        opnd_q <= wr_data;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/rf_access_sequencer.sv
// Operand-fetch initiator for a 1-clock registered-read register file, with writeback pass-through and forwarding.
// Latency: accept edge E0 -> opnd_valid after E2; back-to-back 1 op per 3 clocks.
// Backpressure: op_ready low while busy; operands held (and kept current) until opnd_ready.
module rf_access_sequencer
    import mips_rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter bit ZERO_REG = RF_ZERO_REG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [ADDR_W-1:0] op_rs,
    input  logic [ADDR_W-1:0] op_rt,
    output logic              opnd_valid,
    input  logic              opnd_ready,
    output logic [DATA_W-1:0] opnd_a,
    output logic [DATA_W-1:0] opnd_b,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] rf_ra,
    output logic [ADDR_W-1:0] rf_rb,
    output logic [ADDR_W-1:0] rf_rw,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_busw,
    input  logic [DATA_W-1:0] rf_busa,
    input  logic [DATA_W-1:0] rf_busb
);

    state_t state;
    logic   accept;

    // A new request can enter from IDLE, or from HOLD on the same edge the held result is taken
    assign op_ready = (state == IDLE) || ((state == HOLD) && opnd_ready);
    assign accept   = op_valid && op_ready;

    // Writeback is a straight pass-through; register 0 writes are dropped when it is hardwired
    assign rf_rw   = wb_reg;
    assign rf_busw = wb_data;
    assign rf_we   = wb_en && !(ZERO_REG && (wb_reg == '0));

    // Sequencing FSM with registered opnd_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            opnd_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept)
                        state <= ISSUE;
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    state      <= HOLD;
                    opnd_valid <= 1'b1;
                end
                HOLD: begin
                    if (opnd_ready) begin
                        opnd_valid <= 1'b0;
                        state      <= accept ? ISSUE : IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    opnd_valid <= 1'b0;
                end
            endcase
        end
    end

    rf_opnd_fwd #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_opnd_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .state   (state),
        .accept  (accept),
        .new_idx (op_rs),
        .wr_en   (rf_we),
        .wr_reg  (wb_reg),
        .wr_data (wb_data),
        .rf_bus  (rf_busa),
        .idx     (rf_ra),
        .opnd    (opnd_a)
    );

    rf_opnd_fwd #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_opnd_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .state   (state),
        .accept  (accept),
        .new_idx (op_rt),
        .wr_en   (rf_we),
        .wr_reg  (wb_reg),
        .wr_data (wb_data),
        .rf_bus  (rf_busb),
        .idx     (rf_rb),
        .opnd    (opnd_b)
    );

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Bench for rf_access_sequencer: register-file model, behavioural reference and per-cycle compare.
// Latency: n/a.
// Backpressure: opnd_ready driven both by directed sequences and randomly.
module tb_rf_access_sequencer;
    import mips_rf_pkg::*;

    localparam int DW = RF_DATA_W;
    localparam int AW = RF_ADDR_W;
    localparam int NREG = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          op_valid;
    logic          op_ready;
    logic [AW-1:0] op_rs;
    logic [AW-1:0] op_rt;
    logic          opnd_valid;
    logic          opnd_ready;
    logic [DW-1:0] opnd_a;
    logic [DW-1:0] opnd_b;
    logic          wb_en;
    logic [AW-1:0] wb_reg;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] rf_ra;
    logic [AW-1:0] rf_rb;
    logic [AW-1:0] rf_rw;
    logic          rf_we;
    logic [DW-1:0] rf_busw;
    logic [DW-1:0] rf_busa;
    logic [DW-1:0] rf_busb;

    int n_checks = 0;
    int n_pass   = 0;

    rf_access_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_rs      (op_rs),
        .op_rt      (op_rt),
        .opnd_valid (opnd_valid),
        .opnd_ready (opnd_ready),
        .opnd_a     (opnd_a),
        .opnd_b     (opnd_b),
        .wb_en      (wb_en),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .rf_ra      (rf_ra),
        .rf_rb      (rf_rb),
        .rf_rw      (rf_rw),
        .rf_we      (rf_we),
        .rf_busw    (rf_busw),
        .rf_busa    (rf_busa),
        .rf_busb    (rf_busb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: registered read returning pre-write contents; r0 holds junk to prove zeroing
    logic [DW-1:0] file_mem [NREG];
    always @(posedge clk) begin
        rf_busa <= file_mem[rf_ra];
        rf_busb <= file_mem[rf_rb];
        if (rf_we) file_mem[rf_rw] <= rf_busw;
    end

    // Reference: architectural register contents plus a transaction-level view of the handshake
    logic [DW-1:0] m_reg [NREG];
    bit            m_busy;
    int            m_age;
    logic [AW-1:0] m_rs;
    logic [AW-1:0] m_rt;

    initial begin
        for (int i = 0; i < NREG; i++) begin
            file_mem[i] = DW'(i * 'h010101 + 'h10);
            m_reg[i]    = DW'(i * 'h010101 + 'h10);
        end
        file_mem[0] = DW'('hDEAD00);
        m_reg[0]    = '0;
    end

    function automatic bit m_valid();
        return m_busy && (m_age >= 2);
    endfunction

    function automatic logic [DW-1:0] exp_opnd(input logic [AW-1:0] idx);
        return (idx == 0) ? '0 : m_reg[idx];
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_upd
        bit v;
        bit rdy;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_rs   = '0;
            m_rt   = '0;
        end else begin
            v   = m_valid();
            rdy = !m_busy || (v && opnd_ready);
            if (wb_en && wb_reg != 0) m_reg[wb_reg] = wb_data;
            if (op_valid && rdy) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_rs   = op_rs;
                m_rt   = op_rt;
            end else if (v && opnd_ready) begin
                m_busy = 1'b0;
            end else if (m_busy && m_age < 2) begin
                m_age = m_age + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Per-cycle compare against the reference, away from the active edge
    always @(negedge clk) begin : compare
        bit v;
        if (rst_n) begin
            v = m_valid();
            chk("opnd_valid", 32'(opnd_valid), 32'(v));
            chk("op_ready", 32'(op_ready), 32'(!m_busy || (v && opnd_ready)));
            chk("rf_ra", 32'(rf_ra), 32'(m_rs));
            chk("rf_rb", 32'(rf_rb), 32'(m_rt));
            chk("rf_we", 32'(rf_we), 32'(wb_en && wb_reg != 0));
            chk("rf_rw", 32'(rf_rw), 32'(wb_reg));
            chk("rf_busw", 32'(rf_busw), 32'(wb_data));
            if (v) begin
                chk("opnd_a", 32'(opnd_a), 32'(exp_opnd(m_rs)));
                chk("opnd_b", 32'(opnd_b), 32'(exp_opnd(m_rt)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] r, input logic [DW-1:0] d);
        wb_en   = 1'b1;
        wb_reg  = r;
        wb_data = d;
        step();
        wb_en   = 1'b0;
    endtask

    // Presents a request for one cycle; the caller ensures op_ready is high
    task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        op_valid = 1'b1;
        op_rs    = rs;
        op_rt    = rt;
        step();
        op_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        op_valid   = 1'b0;
        op_rs      = '0;
        op_rt      = '0;
        opnd_ready = 1'b1;
        wb_en      = 1'b0;
        wb_reg     = '0;
        wb_data    = '0;

        // Reset state
        #2;
        chk("rst_opnd_valid", 32'(opnd_valid), 32'd0);
        chk("rst_op_ready", 32'(op_ready), 32'd1);
        chk("rst_rf_ra", 32'(rf_ra), 32'd0);
        chk("rst_rf_rb", 32'(rf_rb), 32'd0);
        chk("rst_opnd_a", 32'(opnd_a), 32'd0);
        chk("rst_opnd_b", 32'(opnd_b), 32'd0);
        #10;
        rst_n = 1'b1;
        step();

        // Basic fetch after preload
        wr(3'd3, 24'h00ABCD);
        wr(3'd5, 24'h123456);
        issue(3'd3, 3'd5);
        chk("t1_rf_ra", 32'(rf_ra), 32'd3);
        step();
        chk("t1_valid_e1", 32'(opnd_valid), 32'd0);
        step();
        chk("t1_valid_e2", 32'(opnd_valid), 32'd1);
        chk("t1_a", 32'(opnd_a), 32'h00ABCD);
        chk("t1_b", 32'(opnd_b), 32'h123456);
        step();

        // Forwarding in ISSUE
        wr(3'd2, 24'h0000AA);
        opnd_ready = 1'b0;
        issue(3'd2, 3'd1);
        wb_en = 1'b1; wb_reg = 3'd2; wb_data = 24'h0000FF;
        step();
        wb_en = 1'b0;
        step();
        chk("t2_issue_fwd", 32'(opnd_a), 32'h0000FF);
        opnd_ready = 1'b1;
        step();
        opnd_ready = 1'b0;
        // Forwarding in CAPTURE, then in HOLD
        wr(3'd2, 24'h0000AA);
        issue(3'd2, 3'd1);
        step();
        wb_en = 1'b1; wb_reg = 3'd2; wb_data = 24'h0000FF;
        step();
        chk("t2_capture_fwd", 32'(opnd_a), 32'h0000FF);
        wb_data = 24'h111111;
        step();
        wb_en = 1'b0;
        chk("t2_hold_fwd", 32'(opnd_a), 32'h111111);
        chk("t2_hold_valid", 32'(opnd_valid), 32'd1);
        opnd_ready = 1'b1;
        step();

        // Hardwired register 0
        wb_en = 1'b1; wb_reg = 3'd0; wb_data = 24'hFFFFFF;
        #1;
        chk("t3_we_r0", 32'(rf_we), 32'd0);
        step();
        wb_en = 1'b0;
        issue(3'd0, 3'd0);
        step();
        step();
        chk("t3_a_zero", 32'(opnd_a), 32'd0);
        chk("t3_b_zero", 32'(opnd_b), 32'd0);
        step();

        // Consumer stall, then release with a new request on the same edge
        opnd_ready = 1'b0;
        issue(3'd3, 3'd5);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_valid", 32'(opnd_valid), 32'd1);
            chk("t4_stall_op_ready", 32'(op_ready), 32'd0);
            chk("t4_stall_a", 32'(opnd_a), 32'h00ABCD);
            chk("t4_stall_b", 32'(opnd_b), 32'h123456);
            step();
        end
        opnd_ready = 1'b1;
        op_valid   = 1'b1;
        op_rs      = 3'd5;
        op_rt      = 3'd3;
        #1;
        chk("t4_ready_on_release", 32'(op_ready), 32'd1);
        step();
        op_valid = 1'b0;
        chk("t4_valid_after_release", 32'(opnd_valid), 32'd0);
        chk("t4_rf_ra_new", 32'(rf_ra), 32'd5);
        step();
        chk("t4_valid_e1", 32'(opnd_valid), 32'd0);
        step();
        chk("t4_valid_e2", 32'(opnd_valid), 32'd1);
        chk("t4_a", 32'(opnd_a), 32'h123456);
        chk("t4_b", 32'(opnd_b), 32'h00ABCD);
        step();

        // Reset during CAPTURE
        issue(3'd3, 3'd5);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(opnd_valid), 32'd0);
        chk("t5_rst_op_ready", 32'(op_ready), 32'd1);
        chk("t5_rst_rf_ra", 32'(rf_ra), 32'd0);
        #10;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_no_stale", 32'(opnd_valid), 32'd0);
        end

        // Both operands from the same register, forwarded in ISSUE
        wr(3'd4, 24'h000444);
        opnd_ready = 1'b0;
        issue(3'd4, 3'd4);
        wb_en = 1'b1; wb_reg = 3'd4; wb_data = 24'h00C0DE;
        step();
        wb_en = 1'b0;
        step();
        chk("t6_a", 32'(opnd_a), 32'h00C0DE);
        chk("t6_b", 32'(opnd_b), 32'h00C0DE);
        opnd_ready = 1'b1;
        step();

        // Random traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            op_valid   = ($urandom_range(0, 1) == 1);
            op_rs      = AW'($urandom);
            op_rt      = AW'($urandom);
            opnd_ready = ($urandom_range(0, 3) != 0);
            wb_en      = ($urandom_range(0, 1) == 1);
            wb_reg     = AW'($urandom);
            wb_data    = DW'($urandom);
            step();
        end
        op_valid = 1'b0;
        wb_en    = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
